interrupt_sequencer: RTL and testbench

Consumes the single-cycle interrupt request and 5-bit interrupt number from the interrupt handler and steers the processor into and out of the service routine. On a request it waits for a pipeline safe point, flushes, saves the return PC, and loads the vector address. On return-from-interrupt it restores the PC and pulses the handler's enable input. It sits between the interrupt handler and the PC/fetch logic.

---
 rtl/interrupt_sequencer_if.sv | 39 +++
 rtl/interrupt_sequencer.sv | 103 ++++++++++
 tb/tb_interrupt_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// interrupt_sequencer_if : request/return and PC-steering signals of the
// interrupt sequencer.   Revision 1.0
// ----------------------------------------------------------------------------
interface interrupt_sequencer_if #(
   parameter int PC_WIDTH = 16
);
   logic                irq_in;
   logic [4:0]          irq_number;
   logic                stall;
   logic [PC_WIDTH-1:0] current_pc;
   logic                reti;
   logic                ei;
   logic                di;
   logic                flush;
   logic                pc_load;
   logic [PC_WIDTH-1:0] pc_load_value;
   logic [PC_WIDTH-1:0] epc;
   logic [4:0]          cause;
   logic                in_service;
   logic                int_enable;
   logic                int_disable;
   logic                lost_irq;

   // master: handler/pipeline side driving requests and observing steering
   modport master (
      output irq_in, irq_number, stall, current_pc, reti, ei, di,
      input  flush, pc_load, pc_load_value, epc, cause,
             in_service, int_enable, int_disable, lost_irq
   );

   modport slave (
      input  irq_in, irq_number, stall, current_pc, reti, ei, di,
      output flush, pc_load, pc_load_value, epc, cause,
             in_service, int_enable, int_disable, lost_irq
   );
endinterface
`default_nettype wire

// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// interrupt_sequencer : steers fetch into the vector on a request and back to
// the saved PC on return-from-interrupt.   Revision 1.0
// ----------------------------------------------------------------------------
module interrupt_sequencer #(
   parameter int                  PC_WIDTH           = 16,
   parameter logic [PC_WIDTH-1:0] VECTOR_BASE        = 16'h0100,
   parameter int                  VECTOR_STRIDE_LOG2 = 2
) (
   input  logic                clock,
   input  logic                reset,
   interrupt_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PENDING = 3'd1,
      S_FLUSH   = 3'd2,
      S_VECTOR  = 3'd3,
      S_SERVICE = 3'd4,
      S_RETURN  = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] epc_q, epc_d;
   logic [4:0]          cause_q, cause_d;
   logic                lost_irq_q, lost_irq_d;
   logic                ei_q, ei_d;
   logic                di_q, di_d;
   logic [PC_WIDTH-1:0] vector_addr;

   // Truncation to PC_WIDTH gives the required modulo wrap of the vector.
   assign vector_addr = VECTOR_BASE + (PC_WIDTH'(cause_q) << VECTOR_STRIDE_LOG2);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         epc_q      <= '0;
         cause_q    <= '0;
         lost_irq_q <= 1'b0;
         ei_q       <= 1'b0;
         di_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         epc_q      <= epc_d;
         cause_q    <= cause_d;
         lost_irq_q <= lost_irq_d;
         ei_q       <= ei_d;
         di_q       <= di_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      epc_d      = epc_q;
      cause_d    = cause_q;
      lost_irq_d = lost_irq_q | (bus.irq_in & (state_q != S_IDLE));
      ei_d       = bus.ei & (state_q == S_IDLE);
      di_d       = bus.di;
      case (state_q)
         S_IDLE: begin
            if (bus.irq_in) begin
               cause_d = bus.irq_number;
               state_d = S_PENDING;
            end
         end
         S_PENDING: begin
            // Return PC is taken at the safe point, not at request time.
            if (!bus.stall) begin
               epc_d   = bus.current_pc;
               state_d = S_FLUSH;
            end
         end
         S_FLUSH:   state_d = S_VECTOR;
         S_VECTOR:  state_d = S_SERVICE;
         S_SERVICE: begin
            if (bus.reti) state_d = S_RETURN;
         end
         S_RETURN:  state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.flush         = (state_q == S_FLUSH);
      bus.pc_load       = (state_q == S_VECTOR) || (state_q == S_RETURN);
      bus.pc_load_value = '0;
      if (state_q == S_VECTOR) begin
         bus.pc_load_value = vector_addr;
      end else if (state_q == S_RETURN) begin
         bus.pc_load_value = epc_q;
      end
      bus.in_service    = (state_q == S_SERVICE);
      bus.int_enable    = (state_q == S_RETURN) | ei_q;
      bus.int_disable   = di_q;
   end

   assign bus.epc      = epc_q;
   assign bus.cause    = cause_q;
   assign bus.lost_irq = lost_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_interrupt_sequencer : randomized request/return scenarios checked against
// a timeline model of the sequencer.   Revision 1.0
// ----------------------------------------------------------------------------
module tb_interrupt_sequencer;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   interrupt_sequencer_if #(.PC_WIDTH(16)) bus ();
   interrupt_sequencer_if #(.PC_WIDTH(16)) bus_w ();

   interrupt_sequencer #(.PC_WIDTH(16), .VECTOR_BASE(16'h0100), .VECTOR_STRIDE_LOG2(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   interrupt_sequencer #(.PC_WIDTH(16), .VECTOR_BASE(16'hFFF0), .VECTOR_STRIDE_LOG2(2)) dut_w (
      .clock (clock),
      .reset (reset),
      .bus   (bus_w)
   );

   int errors = 0;
   int checks = 0;

   // Observations recorded by run_request / run_return
   logic [15:0] pc_seq [0:15];
   int          flush_at, flush_cnt, load_at, load_cnt, svc_first, bad_flush;
   logic [15:0] load_val;
   logic [4:0]  cause_seen;
   logic        ret_load, ret_en, ret_svc, idle_load, idle_en, idle_svc;
   logic [15:0] ret_val, idle_val;

   // Vector = base + n * 2^stride, modulo 2^16
   function automatic logic [15:0] ref_vector(input int base, input int stride_log2, input int n);
      int a;
      a = base + n * (1 << stride_log2);
      return a[15:0];
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      bus.irq_in = 0; bus.irq_number = 0; bus.stall = 0; bus.current_pc = 0;
      bus.reti = 0; bus.ei = 0; bus.di = 0;
      bus_w.irq_in = 0; bus_w.irq_number = 0; bus_w.stall = 0; bus_w.current_pc = 0;
      bus_w.reti = 0; bus_w.ei = 0; bus_w.di = 0;
   endtask

   // Request at edge 0, stall high for edges 1..s; observation i follows edge i.
   task automatic run_request(input int n, input int s);
      bus.irq_in = 1; bus.irq_number = 5'(n); bus.current_pc = pc_seq[0]; bus.stall = 0;
      step();
      bus.irq_in = 0;
      cause_seen = bus.cause;
      flush_at = -1; flush_cnt = 0; load_at = -1; load_cnt = 0; svc_first = -1; bad_flush = 0;
      load_val = 16'hxxxx;
      for (int i = 1; i <= s + 6; i++) begin
         bus.stall      = (i <= s);
         bus.current_pc = pc_seq[i];
         step();
         if (bus.flush) begin
            flush_cnt++;
            flush_at = i;
            if (bus.stall) bad_flush++;
         end
         if (bus.pc_load) begin
            load_cnt++;
            load_at  = i;
            load_val = bus.pc_load_value;
         end
         if (bus.in_service && svc_first < 0) svc_first = i;
      end
      bus.stall = 0;
   endtask

   task automatic run_return();
      bus.reti = 1;
      step();
      bus.reti = 0;
      ret_load = bus.pc_load; ret_val = bus.pc_load_value; ret_en = bus.int_enable; ret_svc = bus.in_service;
      step();
      idle_load = bus.pc_load; idle_val = bus.pc_load_value; idle_en = bus.int_enable; idle_svc = bus.in_service;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1;
      step();
      step();
      checks++;
      if ({bus.flush, bus.pc_load, bus.pc_load_value, bus.epc, bus.cause, bus.in_service,
           bus.int_enable, bus.int_disable, bus.lost_irq} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got flush=%b load=%b val=%h epc=%h cause=%0d svc=%b en=%b dis=%b lost=%b, required all 0",
                  bus.flush, bus.pc_load, bus.pc_load_value, bus.epc, bus.cause, bus.in_service,
                  bus.int_enable, bus.int_disable, bus.lost_irq);
      end
      reset = 0;
      step();
   endtask

   // Checks one full request against the timeline model, then the return.
   task automatic check_request(input string tag, input int n, input int s);
      logic [15:0] exp_vec;
      exp_vec = ref_vector(16'h0100, 2, n);
      run_request(n, s);
      checks++;
      if (cause_seen !== 5'(n)) begin errors++; $display("FAIL %s cause: got %0d required %0d", tag, cause_seen, n); end
      checks++;
      if (flush_cnt !== 1 || flush_at !== s + 1) begin
         errors++; $display("FAIL %s flush_timing: got count=%0d at=%0d required count=1 at=%0d", tag, flush_cnt, flush_at, s + 1);
      end
      checks++;
      if (bad_flush !== 0) begin errors++; $display("FAIL %s flush_during_stall: got %0d required 0", tag, bad_flush); end
      checks++;
      if (load_cnt !== 1 || load_at !== s + 2) begin
         errors++; $display("FAIL %s vector_timing: got count=%0d at=%0d required count=1 at=%0d", tag, load_cnt, load_at, s + 2);
      end
      checks++;
      if (load_val !== exp_vec) begin errors++; $display("FAIL %s vector_value: got %h required %h", tag, load_val, exp_vec); end
      checks++;
      if (bus.epc !== pc_seq[s + 1]) begin errors++; $display("FAIL %s epc: got %h required %h", tag, bus.epc, pc_seq[s + 1]); end
      checks++;
      if (svc_first !== s + 3 || bus.in_service !== 1'b1) begin
         errors++; $display("FAIL %s in_service: got first=%0d now=%b required first=%0d now=1", tag, svc_first, bus.in_service, s + 3);
      end
      checks++;
      if (bus.lost_irq !== 1'b0) begin errors++; $display("FAIL %s lost_irq: got %b required 0", tag, bus.lost_irq); end
      run_return();
      checks++;
      if ({ret_load, ret_en, ret_svc} !== 3'b110 || ret_val !== pc_seq[s + 1]) begin
         errors++; $display("FAIL %s return_cycle: got load=%b en=%b svc=%b val=%h required load=1 en=1 svc=0 val=%h",
                            tag, ret_load, ret_en, ret_svc, ret_val, pc_seq[s + 1]);
      end
      checks++;
      if ({idle_load, idle_en, idle_svc} !== 3'b000 || idle_val !== 16'h0000) begin
         errors++; $display("FAIL %s after_return: got load=%b en=%b svc=%b val=%h required all 0",
                            tag, idle_load, idle_en, idle_svc, idle_val);
      end
   endtask

   task automatic test_request();
      for (int k = 0; k < 16; k++) pc_seq[k] = 16'h0042;
      check_request("directed_n5", 5, 0);
      for (int k = 0; k < 16; k++) pc_seq[k] = 16'($urandom);
      pc_seq[1] = 16'd10; pc_seq[2] = 16'd11; pc_seq[3] = 16'd12; pc_seq[4] = 16'd13;
      check_request("stall3_n5", 5, 3);
      for (int it = 0; it < 8; it++) begin
         for (int k = 0; k < 16; k++) pc_seq[k] = 16'($urandom);
         check_request("random", int'($urandom_range(0, 31)), int'($urandom_range(0, 6)));
      end
   endtask

   task automatic test_back_to_back();
      // Request immediately in the first IDLE cycle after a return.
      for (int k = 0; k < 16; k++) pc_seq[k] = 16'($urandom);
      check_request("b2b_first", 31, 1);
      for (int k = 0; k < 16; k++) pc_seq[k] = 16'($urandom);
      check_request("b2b_second", 0, 0);
   endtask

   task automatic test_ei_di();
      bus.ei = 1;
      step();
      bus.ei = 0;
      checks++;
      if (bus.int_enable !== 1'b1) begin errors++; $display("FAIL ei_idle_pulse: got %b required 1", bus.int_enable); end
      step();
      checks++;
      if (bus.int_enable !== 1'b0) begin errors++; $display("FAIL ei_idle_width: got %b required 0", bus.int_enable); end
      for (int k = 0; k < 16; k++) pc_seq[k] = 16'h2000 + 16'(k);
      run_request(7, 0);
      bus.ei = 1;
      step();
      bus.ei = 0;
      checks++;
      if (bus.int_enable !== 1'b0) begin errors++; $display("FAIL ei_service_ignored: got %b required 0", bus.int_enable); end
      bus.di = 1;
      step();
      bus.di = 0;
      checks++;
      if (bus.int_disable !== 1'b1) begin errors++; $display("FAIL di_service_pulse: got %b required 1", bus.int_disable); end
      step();
      checks++;
      if (bus.int_disable !== 1'b0 || bus.in_service !== 1'b1) begin
         errors++; $display("FAIL di_service_width: got dis=%b svc=%b required dis=0 svc=1", bus.int_disable, bus.in_service);
      end
      run_return();
      // irq and ei on the same IDLE edge: both take effect
      bus.irq_in = 1; bus.irq_number = 5'd3; bus.ei = 1; bus.current_pc = 16'h3000;
      step();
      bus.irq_in = 0; bus.ei = 0;
      checks++;
      if (bus.int_enable !== 1'b1 || bus.cause !== 5'd3) begin
         errors++; $display("FAIL irq_ei_same_edge: got en=%b cause=%0d required en=1 cause=3", bus.int_enable, bus.cause);
      end
      step();
      checks++;
      if (bus.flush !== 1'b1 || bus.int_enable !== 1'b0) begin
         errors++; $display("FAIL irq_ei_flush: got flush=%b en=%b required flush=1 en=0", bus.flush, bus.int_enable);
      end
      step();
      checks++;
      if (bus.pc_load !== 1'b1 || bus.pc_load_value !== ref_vector(16'h0100, 2, 3)) begin
         errors++; $display("FAIL irq_ei_vector: got load=%b val=%h required load=1 val=%h",
                            bus.pc_load, bus.pc_load_value, ref_vector(16'h0100, 2, 3));
      end
      step();
      run_return();
   endtask

   task automatic test_lost_irq();
      for (int k = 0; k < 16; k++) pc_seq[k] = 16'h4400 + 16'(k);
      run_request(5, 0);
      bus.irq_in = 1; bus.irq_number = 5'd9;
      step();
      bus.irq_in = 0;
      checks++;
      if (bus.cause !== 5'd5 || bus.epc !== pc_seq[1] || bus.lost_irq !== 1'b1) begin
         errors++; $display("FAIL lost_irq_in_service: got cause=%0d epc=%h lost=%b required cause=5 epc=%h lost=1",
                            bus.cause, bus.epc, bus.lost_irq, pc_seq[1]);
      end
      run_return();
      checks++;
      if (bus.lost_irq !== 1'b1 || ret_val !== pc_seq[1]) begin
         errors++; $display("FAIL lost_irq_sticky: got lost=%b ret=%h required lost=1 ret=%h", bus.lost_irq, ret_val, pc_seq[1]);
      end
      bus.reti = 1;
      step();
      bus.reti = 0;
      checks++;
      if (bus.pc_load !== 1'b0 || bus.int_enable !== 1'b0 || bus.in_service !== 1'b0) begin
         errors++; $display("FAIL reti_in_idle: got load=%b en=%b svc=%b required all 0", bus.pc_load, bus.int_enable, bus.in_service);
      end
      step();
      checks++;
      if (bus.pc_load !== 1'b0 || bus.flush !== 1'b0) begin
         errors++; $display("FAIL reti_in_idle_after: got load=%b flush=%b required 0 0", bus.pc_load, bus.flush);
      end
   endtask

   task automatic test_wrap();
      bus_w.irq_in = 1; bus_w.irq_number = 5'd31; bus_w.current_pc = 16'h7777;
      step();
      bus_w.irq_in = 0;
      step();
      step();
      checks++;
      if (bus_w.pc_load !== 1'b1 || bus_w.pc_load_value !== ref_vector(16'hFFF0, 2, 31)) begin
         errors++; $display("FAIL vector_wrap: got load=%b val=%h required load=1 val=%h",
                            bus_w.pc_load, bus_w.pc_load_value, ref_vector(16'hFFF0, 2, 31));
      end
      step();
      checks++;
      if (bus_w.in_service !== 1'b1 || bus_w.epc !== 16'h7777) begin
         errors++; $display("FAIL wrap_service: got svc=%b epc=%h required svc=1 epc=7777", bus_w.in_service, bus_w.epc);
      end
   endtask

   task automatic test_reset_mid_service();
      for (int k = 0; k < 16; k++) pc_seq[k] = 16'h1234;
      run_request(int'($urandom_range(1, 31)), 0);
      checks++;
      if (bus.epc !== 16'h1234 || bus.in_service !== 1'b1) begin
         errors++; $display("FAIL pre_reset_state: got epc=%h svc=%b required epc=1234 svc=1", bus.epc, bus.in_service);
      end
      #2;
      reset = 1;
      #1;
      checks++;
      if ({bus.flush, bus.pc_load, bus.pc_load_value, bus.epc, bus.cause, bus.in_service,
           bus.int_enable, bus.int_disable, bus.lost_irq} !== '0) begin
         errors++; $display("FAIL async_reset: got load=%b epc=%h cause=%0d svc=%b lost=%b required all 0",
                            bus.pc_load, bus.epc, bus.cause, bus.in_service, bus.lost_irq);
      end
      step();
      reset = 0;
      step();
      checks++;
      if ({bus.flush, bus.pc_load, bus.pc_load_value, bus.epc, bus.in_service, bus.int_enable} !== '0) begin
         errors++; $display("FAIL after_reset_idle: got flush=%b load=%b val=%h epc=%h svc=%b en=%b required all 0",
                            bus.flush, bus.pc_load, bus.pc_load_value, bus.epc, bus.in_service, bus.int_enable);
      end
      // Still in IDLE: a new request must restart from PENDING.
      for (int k = 0; k < 16; k++) pc_seq[k] = 16'($urandom);
      check_request("post_reset", 2, 2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_request();
      test_back_to_back();
      test_ei_di();
      test_lost_irq();
      test_wrap();
      test_reset_mid_service();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
